// File: rtl/lab3_cache_mem_responder_if.sv
// Request/response link between the cache
// and the memory responder.
interface lab3_cache_mem_responder_if;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [76:0] memreq_msg;
  logic        memresp_val;
  logic        memresp_rdy;
  logic [46:0] memresp_msg;

  modport master (
    output memreq_val,
    output memreq_msg,
    output memresp_rdy,
    input  memreq_rdy,
    input  memresp_val,
    input  memresp_msg
  );

  modport slave (
    input  memreq_val,
    input  memreq_msg,
    input  memresp_rdy,
    output memreq_rdy,
    output memresp_val,
    output memresp_msg
  );
endinterface

// File: rtl/lab3_cache_mem_responder.sv
// Word-array main memory with fixed response
// latency, one transaction in flight.
module lab3_cache_mem_responder #(
  parameter int p_num_words = 256,
  parameter int p_latency   = 2
) (
  input logic clk,
  input logic reset,
  lab3_cache_mem_responder_if.slave mem
);
  localparam int IW = $clog2(p_num_words);
  localparam logic [3:0] LAT_M1 =
    4'(p_latency - 1);

  if (p_latency < 1 || p_latency > 15) begin : g_bad_lat
    $error("p_latency out of range 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [3:0]      count;
  logic [2:0]      req_type;
  logic [7:0]      req_opaque;
  logic [1:0]      req_len;
  logic [IW-1:0]   req_idx;
  logic [46:0]     resp_msg;
  logic [31:0]     mem_array [p_num_words];

  logic [2:0]      in_type;
  logic [7:0]      in_opaque;
  logic [IW-1:0]   in_idx;
  logic [1:0]      in_len;
  logic [31:0]     in_data;
  logic            go;
  logic [IW-1:0]   rd_idx;
  logic [31:0]     rd_data;
  logic [46:0]     in_resp;
  logic [46:0]     req_resp;
  logic            unused_addr;

  assign in_type   = mem.memreq_msg[76:74];
  assign in_opaque = mem.memreq_msg[73:66];
  assign in_idx    = mem.memreq_msg[IW+35:36];
  assign in_len    = mem.memreq_msg[33:32];
  assign in_data   = mem.memreq_msg[31:0];

  // Byte offset and upper address bits never select a word.
  assign unused_addr = ^{
    mem.memreq_msg[65:IW+36],
    mem.memreq_msg[35:34]
  };

  assign go = mem.memreq_val && mem.memreq_rdy;

  assign mem.memreq_rdy =
    (state == IDLE) ||
    (state == RESP && mem.memresp_rdy);
  assign mem.memresp_val = (state == RESP);
  assign mem.memresp_msg = resp_msg;

  // In WAIT the stored request is read; otherwise the
  // incoming one (only needed when p_latency is 1).
  assign rd_idx  = (state == WAIT) ? req_idx : in_idx;
  assign rd_data = mem_array[rd_idx];

  function automatic logic [46:0] mk_resp(
    input logic [2:0]  ty,
    input logic [7:0]  op,
    input logic [1:0]  ln,
    input logic [31:0] rd
  );
    logic [31:0] d;
    d = (ty == 3'd0) ? rd : 32'd0;
    return {ty, op, 2'b00, ln, d};
  endfunction

  assign in_resp  = mk_resp(in_type, in_opaque,
                            in_len, rd_data);
  assign req_resp = mk_resp(req_type, req_opaque,
                            req_len, rd_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      resp_msg <= '0;
    end else if (go) begin
      req_type   <= in_type;
      req_opaque <= in_opaque;
      req_len    <= in_len;
      req_idx    <= in_idx;
      if (p_latency == 1) begin
        state    <= RESP;
        resp_msg <= in_resp;
      end else begin
        state <= WAIT;
        count <= LAT_M1;
      end
    end else begin
      unique case (state)
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state    <= RESP;
            resp_msg <= req_resp;
          end
        end
        RESP: if (mem.memresp_rdy) state <= IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (go && !reset &&
        (in_type == 3'd1 || in_type == 3'd2))
      mem_array[in_idx] <= in_data;
  end
endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// Directed and random transactions against a
// word-array reference model.
module tb_lab3_cache_mem_responder;
  localparam int NW    = 256;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] mdl_a [NW];
  logic [31:0] known [$];

  always #5 clk = ~clk;

  lab3_cache_mem_responder_if a ();
  lab3_cache_mem_responder_if b ();

  lab3_cache_mem_responder #(
    .p_num_words(NW),
    .p_latency(LAT_A)
  ) dut_a (
    .clk(clk),
    .reset(reset),
    .mem(a.slave)
  );

  lab3_cache_mem_responder #(
    .p_num_words(NW),
    .p_latency(LAT_B)
  ) dut_b (
    .clk(clk),
    .reset(reset),
    .mem(b.slave)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [76:0] mk_req(
    input logic [2:0]  ty,
    input logic [7:0]  op,
    input logic [31:0] ad,
    input logic [1:0]  ln,
    input logic [31:0] dt
  );
    return {ty, op, ad, ln, dt};
  endfunction

  function automatic logic [46:0] model_a(
    input logic [2:0]  ty,
    input logic [31:0] ad,
    input logic [31:0] dt,
    input logic [7:0]  op,
    input logic [1:0]  ln
  );
    int w;
    logic [31:0] d;
    w = int'((ad / 4) % NW);
    d = 32'd0;
    if (ty == 3'd0) d = mdl_a[w];
    if (ty == 3'd1 || ty == 3'd2) mdl_a[w] = dt;
    return {ty, op, 2'b00, ln, d};
  endfunction

  task automatic a_txn(
    input logic [2:0]  ty,
    input logic [31:0] ad,
    input logic [31:0] dt,
    input logic [7:0]  op,
    input logic [1:0]  ln,
    input int          hold
  );
    logic [46:0] exp;
    int n;
    exp = model_a(ty, ad, dt, op, ln);
    a.memresp_rdy = (hold == 0);
    a.memreq_msg  = mk_req(ty, op, ad, ln, dt);
    a.memreq_val  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a.memreq_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_rdy", 64'(a.memreq_rdy), 64'd1);
    @(posedge clk);
    #1;
    a.memreq_val = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a.memresp_val && n < 20);
    chk("latency", 64'(n), 64'(LAT_A));
    chk("resp_msg", 64'(a.memresp_msg), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_val", 64'(a.memresp_val), 64'd1);
      chk("bp_msg", 64'(a.memresp_msg), 64'(exp));
      chk("bp_req_rdy", 64'(a.memreq_rdy), 64'd0);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      a.memresp_rdy = 1'b1;
      @(negedge clk);
      chk("bp_release", 64'(a.memreq_rdy), 64'd1);
    end
    @(posedge clk);
    #1;
  endtask

  logic [76:0] sreq [8];
  logic [46:0] sexp [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a.memreq_val = 1'b0;
    a.memreq_msg = '0;
    a.memresp_rdy = 1'b1;
    b.memreq_val = 1'b0;
    b.memreq_msg = '0;
    b.memresp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 64'(a.memreq_rdy), 64'd1);
    chk("rst_resp_val", 64'(a.memresp_val), 64'd0);
    chk("rst_resp_msg", 64'(a.memresp_msg), 64'd0);
    chk("rst_b_val", 64'(b.memresp_val), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // write then read
    a_txn(3'd1, 32'h100, 32'hDEADBEEF, 8'h05, 2'd0, 0);
    a_txn(3'd0, 32'h100, 32'h0, 8'h06, 2'd0, 0);

    // wrap-around and ignored byte offset
    a_txn(3'd2, 32'h10, 32'h1234, 8'h07, 2'd0, 0);
    a_txn(3'd0, 32'h410, 32'h0, 8'h08, 2'd0, 0);
    a_txn(3'd0, 32'h13, 32'h0, 8'h09, 2'd1, 0);

    // back-pressure for 5 cycles
    a_txn(3'd0, 32'h100, 32'h0, 8'h0A, 2'd0, 5);

    // unknown type leaves the array alone
    a_txn(3'd1, 32'h40, 32'h77, 8'h0B, 2'd0, 0);
    a_txn(3'd5, 32'h40, 32'h99, 8'h0C, 2'd0, 0);
    a_txn(3'd0, 32'h40, 32'h0, 8'h0D, 2'd0, 0);

    // reset while a write waits in the pipe
    a.memreq_msg = mk_req(3'd1, 8'h0E, 32'h300,
                          2'd0, 32'hAA);
    a.memreq_val = 1'b1;
    @(negedge clk);
    chk("rst_wr_rdy", 64'(a.memreq_rdy), 64'd1);
    void'(model_a(3'd1, 32'h300, 32'hAA,
                  8'h0E, 2'd0));
    @(posedge clk);
    #1;
    a.memreq_val = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(a.memreq_rdy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_noresp",
          64'(a.memresp_val), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    a_txn(3'd0, 32'h300, 32'h0, 8'h0F, 2'd0, 0);

    // random mix against the model
    known.push_back(32'h100);
    known.push_back(32'h10);
    known.push_back(32'h40);
    known.push_back(32'h300);
    for (int i = 0; i < 30; i++) begin
      int sel;
      logic [31:0] ad;
      logic [31:0] base;
      logic [2:0]  ty;
      sel = $urandom_range(0, 3);
      ad  = $urandom;
      if (sel == 0) begin
        base = known[$urandom_range(0,
                      known.size() - 1)];
        ad = (ad & 32'hFFFF_FC03) |
             (base & 32'h0000_03FC);
        ty = 3'd0;
      end else if (sel == 1) begin
        ty = 3'($urandom_range(1, 2));
        known.push_back(ad);
      end else begin
        ty = 3'($urandom_range(3, 7));
      end
      a_txn(ty, ad, $urandom, 8'($urandom),
            2'($urandom), $urandom_range(0, 3));
    end

    // latency-1 streaming: 4 writes then 4 reads
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      logic [31:0] ad;
      d  = $urandom;
      ad = 32'h200 + 32'(4 * i);
      sreq[i]     = mk_req(3'd1, 8'(8 + i), ad,
                           2'd0, d);
      sexp[i]     = {3'd1, 8'(8 + i), 2'b00,
                     2'd0, 32'd0};
      sreq[i + 4] = mk_req(3'd0, 8'(i), ad,
                           2'd0, 32'd0);
      sexp[i + 4] = {3'd0, 8'(i), 2'b00,
                     2'd0, d};
    end
    b.memreq_msg = sreq[0];
    b.memreq_val = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8)
        chk("stream_rdy", 64'(b.memreq_rdy), 64'd1);
      if (k >= 1) begin
        chk("stream_val", 64'(b.memresp_val), 64'd1);
        chk("stream_msg", 64'(b.memresp_msg),
            64'(sexp[k - 1]));
      end
      @(posedge clk);
      #1;
      if (k + 1 < 8) b.memreq_msg = sreq[k + 1];
      else b.memreq_val = 1'b0;
    end
    @(negedge clk);
    chk("stream_idle", 64'(b.memresp_val), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
